// File: rtl/mux_sync_arb.sv
// Source-side scheduler for a MUX-synchronizer crossing: round-robin grants onto a registered
// bus, holding data/enable for HOLD_CYC cycles, then data only for a GAP_CYC guard gap.
module mux_sync_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 4,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic                    clka,
  input  logic                    rst,
  input  logic                    arb_en_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*DW-1:0]      data_in_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [DW-1:0]           bus_data_o,
  output logic                    bus_en_o,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] last_id_o
);

  localparam int unsigned IdW     = $clog2(NREQ);
  localparam int unsigned MaxHold = (HOLD_CYC > 2) ? HOLD_CYC : 2;
  localparam int unsigned MaxCyc  = (MaxHold > GAP_CYC) ? MaxHold : GAP_CYC;
  localparam int unsigned CntW    = $clog2(MaxCyc);

  localparam logic [CntW-1:0] HoldInit = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapInit  = CntW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IdW-1:0]  PtrInit  = IdW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdW-1:0]    ptr_q;
  logic [IdW-1:0]    last_id_q;
  logic [NREQ-1:0]   gnt_q;
  logic [DW-1:0]     bus_data_q;
  logic              bus_en_q;
  logic              busy_q;

  logic [NREQ-1:0]   rot;
  logic              win_found;
  int unsigned       win_off;
  logic [IdW-1:0]    win_id;
  logic [NREQ-1:0]   win_oh;

  // rot[j] is the request of requester (ptr+1+j) mod NREQ; lowest set bit wins.
  always_comb begin
    rot       = NREQ'({req_i, req_i} >> (32'(ptr_q) + 32'd1));
    win_found = 1'b0;
    win_off   = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        win_found = 1'b1;
        win_off   = unsigned'(j);
      end
    end
    win_id = IdW'((32'(ptr_q) + 32'd1 + win_off) % NREQ);
    win_oh = NREQ'(1) << win_id;
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= PtrInit;
      last_id_q  <= '0;
      gnt_q      <= '0;
      bus_data_q <= '0;
      bus_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      gnt_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (arb_en_i && win_found) begin
            bus_data_q <= data_in_i[32'(win_id)*DW +: DW];
            bus_en_q   <= 1'b1;
            gnt_q      <= win_oh;
            last_id_q  <= win_id;
            ptr_q      <= win_id;
            cnt_q      <= HoldInit;
            busy_q     <= 1'b1;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            bus_en_q <= 1'b0;
            if (GAP_CYC > 0) begin
              cnt_q   <= GapInit;
              state_q <= StGap;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StGap: begin
          // Data stays frozen so the destination enable can fall before the bus changes.
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign bus_data_o = bus_data_q;
  assign bus_en_o   = bus_en_q;
  assign busy_o     = busy_q;
  assign last_id_o  = last_id_q;

endmodule

// File: tb/tb_mux_sync_arb.sv
// Scoreboard bench for mux_sync_arb: stimulus queues expected grants, a monitor checks each
// grant pulse plus bus_en window length and grant spacing.
module tb_mux_sync_arb;

  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic             clka   = 1'b0;
  logic             rst    = 1'b0;
  logic             arb_en = 1'b1;
  logic [NREQ-1:0]  req    = '0;
  logic [NREQ*DW-1:0] data = '0;
  logic [NREQ-1:0]  gnt;
  logic [DW-1:0]    bus_data;
  logic             bus_en;
  logic             busy;
  logic [1:0]       last_id;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   auto_drop  = 1'b1;
  bit   spacing_en = 1'b0;

  mux_sync_arb #(
    .NREQ    (NREQ),
    .DW      (DW),
    .HOLD_CYC(HOLD),
    .GAP_CYC (GAP)
  ) dut (
    .clka      (clka),
    .rst       (rst),
    .arb_en_i  (arb_en),
    .req_i     (req),
    .data_in_i (data),
    .gnt_o     (gnt),
    .bus_data_o(bus_data),
    .bus_en_o  (bus_en),
    .busy_o    (busy),
    .last_id_o (last_id)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Requesters drop a request the cycle its grant is seen.
  task automatic step();
    @(posedge clka);
    #2;
    if (auto_drop) req = req & ~gnt;
  endtask

  task automatic wait_gnt(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = (gnt != '0);
    end
    if (!got) chk({name, "_gnt_timeout"}, 0, 1);
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_bus_en"}, int'(bus_en), 0);
    chk({name, "_outputs"}, int'({gnt, bus_data, busy, last_id}), 0);
  endtask

  // Monitor: grant pulses, bus_en window length, grant spacing under load.
  initial begin
    int   run;
    int   prev;
    int   cyc;
    exp_t e;
    run  = 0;
    prev = -1;
    cyc  = 0;
    forever begin
      @(negedge clka);
      cyc++;
      if (rst) begin
        run  = 0;
        prev = -1;
      end else begin
        if (bus_en) begin
          run++;
        end else if (run != 0) begin
          chk("bus_en_len", run, HOLD);
          run = 0;
        end
        if (gnt != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_gnt", int'(gnt), 0);
          end else begin
            e = exp_q.pop_front();
            chk("gnt_onehot", int'(gnt), 1 << e.id);
            chk("bus_data", int'(bus_data), e.data);
            chk("last_id", int'(last_id), e.id);
            chk("bus_en_at_gnt", int'(bus_en), 1);
          end
          if (spacing_en && prev >= 0) chk("gnt_spacing", cyc - prev, HOLD + GAP + 1);
          prev = cyc;
        end
      end
    end
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    #2 check_zero("reset_state");
    step();
    rst = 1'b0;
    step();
    check_zero("idle_after_reset");

    // 1: single requester
    data[7:4] = 4'hA;
    req = 4'b0010;
    push(1, 'hA);
    wait_gnt("t1");
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("t1_busy_cycles", n, HOLD + GAP);
    chk("t1_last_id", int'(last_id), 1);
    chk("t1_data_hold", int'(bus_data), 'hA);
    repeat (3) step();

    // 2: all four from reset, continuous load
    rst = 1'b1;
    step();
    rst = 1'b0;
    data = {4'h4, 4'h3, 4'h2, 4'h1};
    spacing_en = 1'b1;
    for (int i = 0; i < NREQ; i++) push(i, i + 1);
    req = 4'b1111;
    wait_empty("t2", 60);
    spacing_en = 1'b0;
    repeat (8) step();

    // 3: req[0] and req[2] held high, pointer at 3
    data = {4'h0, 4'hD, 4'h0, 4'hC};
    auto_drop = 1'b0;
    push(0, 'hC);
    push(2, 'hD);
    push(0, 'hC);
    push(2, 'hD);
    req = 4'b0101;
    wait_empty("t3", 60);
    req = '0;
    auto_drop = 1'b1;
    repeat (10) step();

    // 4: reset on the second HOLD cycle of a req[2] transfer
    data[11:8] = 4'h7;
    req = 4'b0100;
    push(2, 'h7);
    wait_gnt("t4");
    step();
    rst = 1'b1;
    #1 check_zero("t4_reset_mid");
    step();
    step();
    rst = 1'b0;
    data[11:8]  = 4'h5;
    data[15:12] = 4'h6;
    push(2, 'h5);
    push(3, 'h6);
    req = 4'b1100;
    wait_empty("t4b", 40);
    repeat (8) step();

    // 5: arb_en gating
    arb_en = 1'b0;
    data[3:0] = 4'h9;
    req = 4'b0001;
    n = 0;
    repeat (20) begin
      step();
      if (gnt != '0 || busy) n++;
    end
    chk("t5_blocked", n, 0);
    push(0, 'h9);
    arb_en = 1'b1;
    step();
    chk("t5_gnt_next", int'(gnt), 1);
    step();
    arb_en = 1'b0;
    req = 4'b0001;
    n = 0;
    repeat (20) begin
      step();
      if (gnt != '0) n++;
    end
    chk("t5_no_more", n, 0);
    chk("t5_idle", int'(busy), 0);

    req = '0;
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
